// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter feeding one shared FIFO
// A grant holds for up to BURST_LEN words; fifo_full stalls the burst but never ends it.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state, state_next;
    logic [NUM_REQ-1:0]  grant_next;
    logic [IDX_W-1:0]    last, last_next;
    logic [BEAT_W-1:0]   beat, beat_next;
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic                owner_valid;

    // Search starts just after the previous owner so nobody can win twice in a row over a waiter.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = last;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        busy        = (state == GRANT);
        req_ready   = (busy && !fifo_full) ? grant : '0;
        owner_valid = |(req_valid & grant);
        wr          = |(req_valid & req_ready);
        w_data      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                w_data = w_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (!wr) begin
            w_data = '0;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        beat_next  = beat;
        case (state)
            IDLE: begin
                if (found && !fifo_full) begin
                    state_next = GRANT;
                    grant_next = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    last_next  = pick;
                    beat_next  = '0;
                end
            end
            GRANT: begin
                if (wr) begin
                    beat_next = beat + BEAT_W'(1);
                    if (beat_next == BEAT_W'(BURST_LEN)) begin
                        state_next = IDLE;
                        grant_next = '0;
                    end
                end else if (!owner_valid) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= '0;
            last  <= IDX_W'(NUM_REQ - 1);
            beat  <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
            beat  <= beat_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed bench for fifo_wr_arbiter (2 requesters, bursts of 4)
module tb_fifo_wr_arbiter;

    localparam int DW = 4;
    localparam int NR = 2;
    localparam int BL = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_ready;
    logic           fifo_full = 1'b0;
    logic           wr;
    logic [DW-1:0]  w_data;
    logic [NR-1:0]  grant;
    logic           busy;

    int compared = 0;
    int mismatched = 0;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BURST_LEN(BL)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .wr(wr), .w_data(w_data),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [9:0] obs = {busy, grant, req_ready, wr, w_data};

    // Expected {busy, grant, req_ready, wr, w_data} given the grant the bench expects this cycle.
    function automatic logic [9:0] model(input logic [1:0] g, input logic full,
                                         input logic [1:0] v, input logic [7:0] d);
        logic [1:0] er;
        logic       ewr;
        logic [3:0] ed;
        er  = full ? 2'b00 : g;
        ewr = |(er & v);
        ed  = ewr ? (g[0] ? d[3:0] : d[7:4]) : 4'h0;
        return {|g, g, er, ewr, ed};
    endfunction

    always @(negedge clk) begin
        #2;
        compared = compared + 1;
        if (!$onehot0(grant) || (wr && fifo_full) || ($countones(req_ready) > 1) || (dut.beat > BL)) begin
            mismatched = mismatched + 1;
            $display("FAIL invariant t=%0t: grant=%b wr=%b full=%b req_ready=%b beat=%0d",
                     $time, grant, wr, fifo_full, req_ready, dut.beat);
        end
    end

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        req_valid = 2'b11;
        req_data  = 8'h53;
        #1;
        compared = compared + 1;
        if (obs !== 10'b0 || dut.beat !== 3'd0 || dut.last !== 1'b1) begin
            mismatched = mismatched + 1;
            $display("FAIL reset_state: got obs=%b beat=%0d last=%0d want obs=0 beat=0 last=1",
                     obs, dut.beat, dut.last);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        logic [9:0] exp;
        hold_reset();
        req_data = 8'h53;
        req_valid = 2'b11;
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            g = (c == 0 || c == 5 || c == 10) ? 2'b00 : ((c < 5 || c > 10) ? 2'b01 : 2'b10);
            #1;
            exp = model(g, fifo_full, req_valid, req_data);
            compared = compared + 1;
            if (obs !== exp) begin
                mismatched = mismatched + 1;
                $display("FAIL round_robin cycle %0d: got %b want %b", c, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_requester();
        logic [1:0] g;
        logic [9:0] exp;
        hold_reset();
        req_data = 8'hA0;
        req_valid = 2'b10;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            g = (c % 5 == 0) ? 2'b00 : 2'b10;
            #1;
            exp = model(g, fifo_full, req_valid, req_data);
            compared = compared + 1;
            if (obs !== exp) begin
                mismatched = mismatched + 1;
                $display("FAIL single_requester cycle %0d: got %b want %b", c, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fifo_full_stall();
        logic [1:0] g;
        logic [9:0] exp;
        hold_reset();
        req_data = 8'h53;
        req_valid = 2'b11;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            fifo_full = (c >= 3 && c <= 5);
            g = (c == 0 || c == 8) ? 2'b00 : ((c == 9) ? 2'b10 : 2'b01);
            #1;
            exp = model(g, fifo_full, req_valid, req_data);
            compared = compared + 1;
            if (obs !== exp) begin
                mismatched = mismatched + 1;
                $display("FAIL fifo_full_stall cycle %0d: got %b want %b", c, obs, exp);
            end
            @(negedge clk);
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_owner_drop();
        logic [1:0] g;
        logic [9:0] exp;
        hold_reset();
        req_data = 8'h53;
        req_valid = 2'b11;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 2) ? 2'b11 : 2'b10;
            g = (c == 0 || c == 3) ? 2'b00 : ((c == 4) ? 2'b10 : 2'b01);
            #1;
            exp = model(g, fifo_full, req_valid, req_data);
            compared = compared + 1;
            if (obs !== exp) begin
                mismatched = mismatched + 1;
                $display("FAIL owner_drop cycle %0d: got %b want %b", c, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rearbitrate();
        logic [1:0] g;
        logic [9:0] exp;
        hold_reset();
        req_data = 8'h53;
        req_valid = 2'b01;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 2) ? 2'b01 : ((c == 2) ? 2'b10 : 2'b11);
            g = (c == 0 || c == 3) ? 2'b00 : ((c == 4) ? 2'b10 : 2'b01);
            #1;
            exp = model(g, fifo_full, req_valid, req_data);
            compared = compared + 1;
            if (obs !== exp) begin
                mismatched = mismatched + 1;
                $display("FAIL rearbitrate cycle %0d: got %b want %b", c, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        hold_reset();
        req_data = 8'h53;
        req_valid = 2'b11;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        compared = compared + 1;
        if (dut.beat !== 3'd2 || obs !== {1'b1, 2'b01, 2'b01, 1'b1, 4'h3}) begin
            mismatched = mismatched + 1;
            $display("FAIL mid_burst_pre: got obs=%b beat=%0d want obs=%b beat=2",
                     obs, dut.beat, {1'b1, 2'b01, 2'b01, 1'b1, 4'h3});
        end
        #1;
        reset = 1'b0;
        #1;
        compared = compared + 1;
        if (obs !== 10'b0 || dut.beat !== 3'd0) begin
            mismatched = mismatched + 1;
            $display("FAIL mid_burst_async: got obs=%b beat=%0d want obs=0 beat=0", obs, dut.beat);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        compared = compared + 1;
        if (obs !== 10'b0) begin
            mismatched = mismatched + 1;
            $display("FAIL mid_burst_release_idle: got %b want %b", obs, 10'b0);
        end
        @(negedge clk);
        #1;
        compared = compared + 1;
        if (obs !== {1'b1, 2'b01, 2'b01, 1'b1, 4'h3}) begin
            mismatched = mismatched + 1;
            $display("FAIL mid_burst_first_grant: got %b want %b", obs, {1'b1, 2'b01, 2'b01, 1'b1, 4'h3});
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_requester();
        test_fifo_full_stall();
        test_owner_drop();
        test_rearbitrate();
        test_reset_mid_burst();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 4, bits per word.
- NUM_REQ, 2, number of producers (legal 2..8).
- BURST_LEN, 4, maximum words per grant (legal 1..16).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- req_valid, in, NUM_REQ, producer i has a word.
- req_data, in, NUM_REQ*DATA_WIDTH, producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, out, NUM_REQ, word of producer i accepted this cycle.
- fifo_full, in, 1, full flag from the shared FIFO.
- wr, out, 1, FIFO write strobe.
- w_data, out, DATA_WIDTH, FIFO write data.
- grant, out, NUM_REQ, one-hot owner; all-zero when idle.
- busy, out, 1, high while in GRANT state.

Function
REQ-003 The block SHALL use two states, IDLE and GRANT, plus registers grant, last (index of most recent owner) and beat (width $clog2(BURST_LEN+1)).
REQ-004 IDLE -> GRANT SHALL occur when any req_valid is high and fifo_full is low. The owner SHALL be the first requester with req_valid high, searching last+1, last+2, ... modulo NUM_REQ.
REQ-005 On that transition, grant SHALL load the one-hot owner, last SHALL load the owner index, and beat SHALL clear to 0.
REQ-006 In IDLE, req_ready, wr and grant SHALL be 0. Arbitration costs exactly one cycle; the first word transfers the cycle after the decision.
REQ-007 In GRANT, req_ready[owner] SHALL equal ~fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-008 wr SHALL equal req_valid[owner] & req_ready[owner]. w_data SHALL equal the owner's req_data slice.
REQ-009 w_data SHALL be all-zero whenever wr is low.
REQ-010 Each cycle with wr high SHALL increment beat.
REQ-011 GRANT -> IDLE SHALL occur at the clock edge following either:
- a transfer that makes beat equal BURST_LEN, or
- a cycle in GRANT with req_valid[owner] low.
On exit, grant SHALL clear to zero.
REQ-012 fifo_full high in GRANT SHALL stall the burst: no write, beat holds, grant holds. The grant SHALL NOT be released because of fifo_full.
REQ-013 A requester that drops valid and reasserts it SHALL re-arbitrate. It SHALL NOT regain ownership ahead of other pending requesters.
REQ-014 Changes to a non-owner req_valid during GRANT SHALL have no effect until the next IDLE cycle.
REQ-015 When only one requester is valid, it SHALL be granted repeatedly. Each grant is separated by one IDLE cycle.
REQ-016 wr SHALL never be high while fifo_full is high. At most one req_ready bit SHALL be high in any cycle.

Reset
REQ-017 While reset is low, outputs and state SHALL immediately take these values, independent of clk:
- state = IDLE, grant = 0, beat = 0, last = NUM_REQ-1 (so requester 0 has first priority), busy = 0.
- req_ready = 0, wr = 0, w_data = 0.
REQ-018 Reset asserted mid-burst SHALL abort the burst with no further write. After reset release, the first arbitration SHALL follow REQ-004 from last = NUM_REQ-1.

Verification
REQ-019 Directed scenarios (NUM_REQ=2, BURST_LEN=4, DATA_WIDTH=4):
- Reset release, both valid continuously, fifo_full=0:
  - grant=01 for 4 writes, then IDLE 1 cycle, then grant=10 for 4 writes, then 01 again.
  - wr pattern: 0,1,1,1,1,0,1,1,1,1.
- Only req 1 valid with data 0xA for 10 cycles -> writes of 0xA in bursts of 4, each burst followed by 1 idle cycle.
- Req 0 granted, fifo_full raised after 2 writes for 3 cycles -> wr=0, req_ready=00 and grant=01 held for those 3 cycles; then 2 more writes; then release.
- Req 0 drops valid after 1 write -> next cycle IDLE; req 1 granted if valid.
- Reset pulled low while beat=2 -> wr=0, grant=00, busy=0 immediately; after release, req 0 is granted first.
- Assertions run throughout all scenarios:
  - grant is one-hot or zero.
  - ~(wr & fifo_full).
  - popcount(req_ready) <= 1.
  - beat <= BURST_LEN.
